// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad geometry, idle row pattern and frame validity check.
package keypad_pkg;
    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam int KEY_NUM  = KEY_ROWS * KEY_COLS;
    localparam logic [KEY_ROWS-1:0] ROW_IDLE = 4'b1110;

    function automatic logic onehot_valid(input logic [KEY_NUM-1:0] frame);
        return $countones(frame) == 1;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs, resets to all-ones.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_q    <= '1;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end
    assign q = r_q;
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: row scan of a 4x4 active-low matrix with frame debounce and multi-key rejection.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_COLS-1:0] col,
    output logic [KEY_ROWS-1:0] row,
    output logic [KEY_NUM-1:0]  onehot,
    output logic                key_valid,
    output logic                key_pulse
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [DIV_W-1:0]    r_div;
    logic [1:0]          r_row_sel;
    logic [KEY_ROWS-1:0] r_row;
    logic [11:0]         r_raw;
    logic [CNT_W-1:0]    r_stable;
    logic [KEY_NUM-1:0]  r_last;
    logic [KEY_NUM-1:0]  r_onehot;
    logic                r_key_valid;
    logic                r_key_pulse;

    logic [KEY_COLS-1:0] w_col_s;
    logic                w_sample;
    logic                w_frame_end;
    logic [1:0]          w_row_sel_nxt;
    logic [KEY_NUM-1:0]  w_frame;
    logic [KEY_NUM-1:0]  w_cand;
    logic [CNT_W-1:0]    w_stable_nxt;
    logic [KEY_NUM-1:0]  w_onehot_nxt;

    sync_2ff #(.W(KEY_COLS)) u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (col),
        .q     (w_col_s)
    );

    // Rows 0..2 shift in from the top so r_raw ends up as {row2,row1,row0}; row 3 comes live.
    always_comb begin
        w_sample      = r_div == DIV_W'(SCAN_DIV - 1);
        w_frame_end   = w_sample && r_row_sel == 2'd3;
        w_row_sel_nxt = r_row_sel + 2'd1;
        w_frame       = {~w_col_s, r_raw};
        w_cand        = onehot_valid(w_frame) ? w_frame : '0;
        w_stable_nxt  = (w_cand != r_last) ? CNT_W'(1) :
                        (r_stable == CNT_W'(DEBOUNCE_SCANS)) ? r_stable : r_stable + CNT_W'(1);
        w_onehot_nxt  = (w_frame_end && w_stable_nxt == CNT_W'(DEBOUNCE_SCANS) && w_cand != r_onehot)
                        ? w_cand : r_onehot;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div       <= '0;
            r_row_sel   <= '0;
            r_row       <= ROW_IDLE;
            r_raw       <= '0;
            r_stable    <= '0;
            r_last      <= '0;
            r_onehot    <= '0;
            r_key_valid <= 1'b0;
            r_key_pulse <= 1'b0;
        end else begin
            r_div <= w_sample ? '0 : r_div + DIV_W'(1);
            if (w_sample) begin
                r_raw     <= {~w_col_s, r_raw[11:4]};
                r_row_sel <= w_row_sel_nxt;
                r_row     <= ~(4'b0001 << w_row_sel_nxt);
            end
            if (w_frame_end) begin
                r_stable <= w_stable_nxt;
                r_last   <= w_cand;
            end
            r_onehot    <= w_onehot_nxt;
            r_key_valid <= |w_onehot_nxt;
            r_key_pulse <= (w_onehot_nxt != r_onehot) && |w_onehot_nxt;
        end
    end

    assign row       = r_row;
    assign onehot    = r_onehot;
    assign key_valid = r_key_valid;
    assign key_pulse = r_key_pulse;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed vector table, reset corner cases and random key frames against a frame-level model.
module tb_keypad_matrix_scanner;
    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] onehot;
    logic        key_valid;
    logic        key_pulse;
    logic [15:0] keys = 16'h0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [15:0] m_onehot = 16'h0;
    logic        m_pulse = 1'b0;
    logic [15:0] hist[$];

    typedef struct {
        logic [15:0] keys;
        int          frames;
        bit          alt;
        logic [15:0] exp_onehot;
        int          exp_pulses;
    } vec_t;
    vec_t vecs[8];

    keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .onehot    (onehot),
        .key_valid (key_valid),
        .key_pulse (key_pulse)
    );

    always #5 clk = ~clk;

    // A pressed key (r,c) pulls column c low whenever row r is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    // onehot follows a candidate once the last DB frame candidates all agree.
    task automatic model_frame(input logic [15:0] m);
        logic [15:0] c;
        bit same;
        c = ($countones(m) == 1) ? m : 16'h0;
        hist.push_back(c);
        if (hist.size() > DB) void'(hist.pop_front());
        same = hist.size() == DB;
        foreach (hist[i]) if (hist[i] != c) same = 0;
        m_pulse = 1'b0;
        if (same && c != m_onehot) begin
            m_onehot = c;
            m_pulse = (c != 0);
        end
    endtask

    task automatic run_frame(input logic [15:0] m);
        logic [3:0] er;
        keys = m;
        for (int k = 1; k <= 4 * SD; k++) begin
            @(posedge clk);
            #1;
            if (k == 4 * SD) model_frame(m);
            else m_pulse = 1'b0;
            er = ~(4'b0001 << ((k / SD) % 4));
            chk("row", {12'h0, row}, {12'h0, er});
            chk("onehot", onehot, m_onehot);
            chk("key_valid", {15'h0, key_valid}, {15'h0, m_onehot != 0});
            chk("key_pulse", {15'h0, key_pulse}, {15'h0, m_pulse});
            pulses += int'(key_pulse);
        end
    endtask

    task automatic reset_model();
        hist.delete();
        m_onehot = 16'h0;
        m_pulse  = 1'b0;
    endtask

    initial begin
        logic [15:0] m;
        int n;
        vecs[0] = '{16'h0040, 3, 1'b0, 16'h0040, 1};
        vecs[1] = '{16'h0040, 10, 1'b0, 16'h0040, 0};
        vecs[2] = '{16'h0000, 3, 1'b0, 16'h0000, 0};
        vecs[3] = '{16'h0800, 8, 1'b1, 16'h0000, 0};
        vecs[4] = '{16'h1008, 6, 1'b0, 16'h0000, 0};
        vecs[5] = '{16'h0008, 3, 1'b0, 16'h0008, 1};
        vecs[6] = '{16'h2000, 3, 1'b0, 16'h2000, 1};
        vecs[7] = '{16'h0000, 3, 1'b0, 16'h0000, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_row", {12'h0, row}, 16'h000E);
        chk("rst_onehot", onehot, 16'h0);
        chk("rst_valid", {15'h0, key_valid}, 16'h0);
        chk("rst_pulse", {15'h0, key_pulse}, 16'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            pulses = 0;
            for (int f = 0; f < vecs[i].frames; f++)
                run_frame((vecs[i].alt && f[0]) ? 16'h0 : vecs[i].keys);
            chk("vec_onehot", onehot, vecs[i].exp_onehot);
            chk("vec_valid", {15'h0, key_valid}, {15'h0, vecs[i].exp_onehot != 0});
            chk("vec_pulses", 16'(pulses), 16'(vecs[i].exp_pulses));
        end

        for (int f = 0; f < 3; f++) run_frame(16'h0040);
        chk("pre_rst_onehot", onehot, 16'h0040);
        repeat (2 * SD) @(posedge clk);
        #1;
        chk("pre_rst_row", {12'h0, row}, 16'h000B);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_onehot", onehot, 16'h0);
        chk("mid_rst_row", {12'h0, row}, 16'h000E);
        chk("mid_rst_valid", {15'h0, key_valid}, 16'h0);
        chk("mid_rst_pulse", {15'h0, key_pulse}, 16'h0);
        rst_n = 1'b1;
        reset_model();
        pulses = 0;
        for (int f = 0; f < 3; f++) run_frame(16'h0040);
        chk("redeb_onehot", onehot, 16'h0040);
        chk("redeb_pulses", 16'(pulses), 16'd1);

        repeat (30) begin
            case ($urandom_range(0, 3))
                0: m = 16'h0;
                1, 2: m = 16'h1 << $urandom_range(0, 15);
                default: m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            endcase
            n = $urandom_range(1, 5);
            repeat (n) run_frame(m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
